// File: rtl/issue_pkg.sv
// Shared types and helpers for the issue stage: queued-op layout, register-file sizing,
// and source-operand usage decode.
package issue_pkg;

  localparam int unsigned REG_W = 5;
  localparam int unsigned NREGS = 32;

  typedef struct packed {
    logic             selalushift;
    logic             selimregb;
    logic             unsig;
    logic             readmem;
    logic             writemem;
    logic             selwsource;
    logic             writereg;
    logic             writeov;
    logic [2:0]       aluop;
    logic [1:0]       shiftop;
    logic [31:0]      imedext;
    logic [REG_W-1:0] regdest;
    logic [1:0]       numop;
    logic [REG_W-1:0] addra;
    logic [REG_W-1:0] addrb;
  } issue_entry_t;

  // idx 1 = source A, idx 2 = source B; numop 3 behaves like 2
  function automatic logic needs_src(input logic [1:0] numop, input logic [1:0] idx);
    return numop >= idx;
  endfunction

endpackage

// File: rtl/issue_queue_if.sv
// Decode->Issue and Issue->Execute bundles; slave is the issue queue side,
// master is the Decode/Execute side.
interface issue_queue_if;
  import issue_pkg::*;

  logic             id_is_valid;
  logic             id_is_selalushift;
  logic             id_is_selimregb;
  logic             id_is_unsig;
  logic             id_is_readmem;
  logic             id_is_writemem;
  logic             id_is_selwsource;
  logic             id_is_writereg;
  logic             id_is_writeov;
  logic [2:0]       id_is_aluop;
  logic [1:0]       id_is_shiftop;
  logic [31:0]      id_is_imedext;
  logic [REG_W-1:0] id_is_regdest;
  logic [1:0]       id_is_numop;
  logic [31:0]      id_is_addra;
  logic [31:0]      id_is_addrb;
  logic             is_if_stall;

  logic             ex_is_ready;
  logic             is_ex_valid;
  logic             is_ex_selalushift;
  logic             is_ex_selimregb;
  logic             is_ex_unsig;
  logic             is_ex_readmem;
  logic             is_ex_writemem;
  logic             is_ex_selwsource;
  logic             is_ex_writereg;
  logic             is_ex_writeov;
  logic [2:0]       is_ex_aluop;
  logic [1:0]       is_ex_shiftop;
  logic [31:0]      is_ex_imedext;
  logic [REG_W-1:0] is_ex_regdest;
  logic [1:0]       is_ex_numop;
  logic [REG_W-1:0] is_ex_addra;
  logic [REG_W-1:0] is_ex_addrb;

  modport slave (
    input  id_is_valid, id_is_selalushift, id_is_selimregb, id_is_unsig, id_is_readmem,
           id_is_writemem, id_is_selwsource, id_is_writereg, id_is_writeov, id_is_aluop,
           id_is_shiftop, id_is_imedext, id_is_regdest, id_is_numop, id_is_addra, id_is_addrb,
           ex_is_ready,
    output is_if_stall, is_ex_valid, is_ex_selalushift, is_ex_selimregb, is_ex_unsig,
           is_ex_readmem, is_ex_writemem, is_ex_selwsource, is_ex_writereg, is_ex_writeov,
           is_ex_aluop, is_ex_shiftop, is_ex_imedext, is_ex_regdest, is_ex_numop,
           is_ex_addra, is_ex_addrb
  );

  modport master (
    output id_is_valid, id_is_selalushift, id_is_selimregb, id_is_unsig, id_is_readmem,
           id_is_writemem, id_is_selwsource, id_is_writereg, id_is_writeov, id_is_aluop,
           id_is_shiftop, id_is_imedext, id_is_regdest, id_is_numop, id_is_addra, id_is_addrb,
           ex_is_ready,
    input  is_if_stall, is_ex_valid, is_ex_selalushift, is_ex_selimregb, is_ex_unsig,
           is_ex_readmem, is_ex_writemem, is_ex_selwsource, is_ex_writereg, is_ex_writeov,
           is_ex_aluop, is_ex_shiftop, is_ex_imedext, is_ex_regdest, is_ex_numop,
           is_ex_addra, is_ex_addrb
  );

endinterface

// File: rtl/issue_scoreboard.sv
// 32-entry register busy scoreboard with one set port, one clear port and two lookups.
// ISSUE_WB_BYPASS_EN: lookups ignore busy bits being cleared by the same-cycle writeback.
module issue_scoreboard
  import issue_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             set_en,
  input  logic [REG_W-1:0] set_idx,
  input  logic             clr_en,
  input  logic [REG_W-1:0] clr_idx,
  input  logic [REG_W-1:0] look_a_idx,
  input  logic [REG_W-1:0] look_b_idx,
  output logic             busy_a,
  output logic             busy_b
);

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;
  logic [NREGS-1:0] set_mask;
  logic [NREGS-1:0] clr_mask;
  logic [NREGS-1:0] busy_eff;

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (set_en) set_mask[set_idx] = 1'b1;
    if (clr_en) clr_mask[clr_idx] = 1'b1;
    // set applied after clear so a collision leaves the register busy
    busy_d    = (busy_q & ~clr_mask) | set_mask;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  always_comb begin
`ifdef ISSUE_WB_BYPASS_EN
    busy_eff = busy_q & ~clr_mask;
`else
    busy_eff = busy_q;
`endif
    busy_a = busy_eff[look_a_idx];
    busy_b = busy_eff[look_b_idx];
  end

endmodule

// File: rtl/issue_queue.sv
// In-order issue FIFO: buffers decoded ops, holds the head on RAW hazards and dispatches
// on a registered bundle. ISSUE_WB_BYPASS_EN enables same-cycle writeback bypass in the scoreboard.
module issue_queue
  import issue_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic             clock,
  input  logic             reset,
  issue_queue_if.slave     ifc,
  input  logic             wb_is_writereg,
  input  logic [REG_W-1:0] wb_is_regdest,
  output logic [PTR_W:0]   is_count
);

  issue_entry_t     fifo_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W:0]   count_q;
  issue_entry_t     in_entry;
  issue_entry_t     head;
  issue_entry_t     ex_q;
  logic             ex_valid_q;
  logic             full;
  logic             empty;
  logic             push;
  logic             fire;
  logic             haz_a;
  logic             haz_b;
  logic             busy_a;
  logic             busy_b;
  logic             sb_set;
  logic             unused_addr_hi;

  assign unused_addr_hi = ^{ifc.id_is_addra[31:REG_W], ifc.id_is_addrb[31:REG_W]};

  always_comb begin
    in_entry             = '0;
    in_entry.selalushift = ifc.id_is_selalushift;
    in_entry.selimregb   = ifc.id_is_selimregb;
    in_entry.unsig       = ifc.id_is_unsig;
    in_entry.readmem     = ifc.id_is_readmem;
    in_entry.writemem    = ifc.id_is_writemem;
    in_entry.selwsource  = ifc.id_is_selwsource;
    in_entry.writereg    = ifc.id_is_writereg;
    in_entry.writeov     = ifc.id_is_writeov;
    in_entry.aluop       = ifc.id_is_aluop;
    in_entry.shiftop     = ifc.id_is_shiftop;
    in_entry.imedext     = ifc.id_is_imedext;
    in_entry.regdest     = ifc.id_is_regdest;
    in_entry.numop       = ifc.id_is_numop;
    in_entry.addra       = ifc.id_is_addra[REG_W-1:0];
    in_entry.addrb       = ifc.id_is_addrb[REG_W-1:0];
  end

  assign head  = fifo_q[rd_ptr_q];
  assign full  = (count_q == (PTR_W+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign push  = ifc.id_is_valid && !full;

  issue_scoreboard u_scoreboard (
    .clock      (clock),
    .reset      (reset),
    .set_en     (sb_set),
    .set_idx    (head.regdest),
    .clr_en     (wb_is_writereg),
    .clr_idx    (wb_is_regdest),
    .look_a_idx (head.addra),
    .look_b_idx (head.addrb),
    .busy_a     (busy_a),
    .busy_b     (busy_b)
  );

  assign haz_a  = needs_src(head.numop, 2'd1) && busy_a && (head.addra != '0);
  assign haz_b  = needs_src(head.numop, 2'd2) && busy_b && (head.addrb != '0);
  assign fire   = !empty && ifc.ex_is_ready && !haz_a && !haz_b;
  assign sb_set = fire && head.writereg && (head.regdest != '0);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) fifo_q[i] <= '0;
      wr_ptr_q <= '0;
    end else if (push) begin
      fifo_q[wr_ptr_q] <= in_entry;
      wr_ptr_q         <= wr_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (fire) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, fire})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ex_q       <= '0;
      ex_valid_q <= 1'b0;
    end else begin
      ex_valid_q <= fire;
      if (fire) ex_q <= head;
    end
  end

  assign is_count              = count_q;
  assign ifc.is_if_stall       = full;
  assign ifc.is_ex_valid       = ex_valid_q;
  assign ifc.is_ex_selalushift = ex_q.selalushift;
  assign ifc.is_ex_selimregb   = ex_q.selimregb;
  assign ifc.is_ex_unsig       = ex_q.unsig;
  assign ifc.is_ex_readmem     = ex_q.readmem;
  assign ifc.is_ex_writemem    = ex_q.writemem;
  assign ifc.is_ex_selwsource  = ex_q.selwsource;
  assign ifc.is_ex_writereg    = ex_q.writereg;
  assign ifc.is_ex_writeov     = ex_q.writeov;
  assign ifc.is_ex_aluop       = ex_q.aluop;
  assign ifc.is_ex_shiftop     = ex_q.shiftop;
  assign ifc.is_ex_imedext     = ex_q.imedext;
  assign ifc.is_ex_regdest     = ex_q.regdest;
  assign ifc.is_ex_numop       = ex_q.numop;
  assign ifc.is_ex_addra       = ex_q.addra;
  assign ifc.is_ex_addrb       = ex_q.addrb;

endmodule

// File: tb/tb_issue_queue.sv
// Directed self-checking bench for issue_queue; expectations for the writeback
// timing follow ISSUE_WB_BYPASS_EN.
module tb_issue_queue;
  import issue_pkg::*;

  logic             clock = 1'b0;
  logic             reset;
  logic             wb_is_writereg;
  logic [REG_W-1:0] wb_is_regdest;
  logic [2:0]       is_count;
  int               n_checks = 0;
  int               n_pass   = 0;

  issue_queue_if ifc ();

  issue_queue #(.DEPTH(4), .PTR_W(2)) dut (
    .clock          (clock),
    .reset          (reset),
    .ifc            (ifc.slave),
    .wb_is_writereg (wb_is_writereg),
    .wb_is_regdest  (wb_is_regdest),
    .is_count       (is_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_op(input logic [4:0] rd, input logic wr, input logic [1:0] nop,
                          input logic [4:0] a, input logic [4:0] b);
    ifc.id_is_valid       = 1'b1;
    ifc.id_is_regdest     = rd;
    ifc.id_is_writereg    = wr;
    ifc.id_is_numop       = nop;
    ifc.id_is_addra       = {27'd0, a};
    ifc.id_is_addrb       = {27'd0, b};
    ifc.id_is_imedext     = 32'hA000_0000 | {27'd0, rd};
    ifc.id_is_aluop       = rd[2:0];
    ifc.id_is_shiftop     = rd[4:3];
    ifc.id_is_selalushift = rd[0];
  endtask

  task automatic idle();
    ifc.id_is_valid = 1'b0;
  endtask

  // Bounded wait for the next dispatch, then check its destination register
  task automatic wait_valid(input string tag, input logic [4:0] exp_rd);
    for (int k = 0; k < 4 && !ifc.is_ex_valid; k++) tick();
    check({tag, "_valid"}, 32'(ifc.is_ex_valid), 32'd1);
    check({tag, "_rd"}, 32'(ifc.is_ex_regdest), 32'(exp_rd));
  endtask

  initial begin
    reset                 = 1'b0;
    wb_is_writereg        = 1'b0;
    wb_is_regdest         = '0;
    ifc.id_is_valid       = 1'b0;
    ifc.id_is_selalushift = 1'b0;
    ifc.id_is_selimregb   = 1'b0;
    ifc.id_is_unsig       = 1'b0;
    ifc.id_is_readmem     = 1'b0;
    ifc.id_is_writemem    = 1'b0;
    ifc.id_is_selwsource  = 1'b0;
    ifc.id_is_writereg    = 1'b0;
    ifc.id_is_writeov     = 1'b0;
    ifc.id_is_aluop       = '0;
    ifc.id_is_shiftop     = '0;
    ifc.id_is_imedext     = '0;
    ifc.id_is_regdest     = '0;
    ifc.id_is_numop       = '0;
    ifc.id_is_addra       = '0;
    ifc.id_is_addrb       = '0;
    ifc.ex_is_ready       = 1'b0;
    tick();
    tick();
    check("rst_count", 32'(is_count), 32'd0);
    check("rst_valid", 32'(ifc.is_ex_valid), 32'd0);
    check("rst_stall", 32'(ifc.is_if_stall), 32'd0);
    check("rst_imm", ifc.is_ex_imedext, 32'd0);
    reset = 1'b1;
    tick();

    // 1: reset mid-stream
    for (int i = 0; i < 3; i++) begin
      drive_op(5'(1 + i), 1'b0, 2'd0, 5'd0, 5'd0);
      tick();
    end
    idle();
    check("t1_count3", 32'(is_count), 32'd3);
    reset = 1'b0;
    #1;
    check("t1_rst_count", 32'(is_count), 32'd0);
    check("t1_rst_valid", 32'(ifc.is_ex_valid), 32'd0);
    check("t1_rst_stall", 32'(ifc.is_if_stall), 32'd0);
    tick();
    reset = 1'b1;
    tick();

    // 2: fill while Execute is not ready, fifth push ignored, drain in order
    for (int i = 0; i < 4; i++) begin
      drive_op(5'(10 + i), 1'b0, 2'd0, 5'd0, 5'd0);
      tick();
    end
    check("t2_full_count", 32'(is_count), 32'd4);
    check("t2_stall", 32'(ifc.is_if_stall), 32'd1);
    drive_op(5'd20, 1'b0, 2'd0, 5'd0, 5'd0);
    tick();
    check("t2_blocked_count", 32'(is_count), 32'd4);
    idle();
    ifc.ex_is_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t2_drain_valid", 32'(ifc.is_ex_valid), 32'd1);
      check("t2_drain_rd", 32'(ifc.is_ex_regdest), 32'(10 + i));
      check("t2_drain_imm", ifc.is_ex_imedext, 32'hA000_0000 + 32'(10 + i));
      check("t2_drain_count", 32'(is_count), 32'(3 - i));
    end
    tick();
    check("t2_idle_valid", 32'(ifc.is_ex_valid), 32'd0);
    check("t2_hold_rd", 32'(ifc.is_ex_regdest), 32'd13);
    check("t2_unstall", 32'(ifc.is_if_stall), 32'd0);

    // 3: RAW hazard on r5 released by writeback
    drive_op(5'd5, 1'b1, 2'd0, 5'd0, 5'd0);
    tick();
    check("t3_latency_valid", 32'(ifc.is_ex_valid), 32'd0);
    drive_op(5'd6, 1'b0, 2'd1, 5'd5, 5'd0);
    tick();
    check("t3_w_valid", 32'(ifc.is_ex_valid), 32'd1);
    check("t3_w_rd", 32'(ifc.is_ex_regdest), 32'd5);
    idle();
    tick();
    check("t3_held", 32'(ifc.is_ex_valid), 32'd0);
    tick();
    check("t3_held2", 32'(ifc.is_ex_valid), 32'd0);
    check("t3_held_count", 32'(is_count), 32'd1);
    wb_is_writereg = 1'b1;
    wb_is_regdest  = 5'd5;
    tick();
    wb_is_writereg = 1'b0;
`ifdef ISSUE_WB_BYPASS_EN
    check("t3_wb_valid", 32'(ifc.is_ex_valid), 32'd1);
    check("t3_wb_rd", 32'(ifc.is_ex_regdest), 32'd6);
    tick();
    check("t3_after", 32'(ifc.is_ex_valid), 32'd0);
`else
    check("t3_wb_valid", 32'(ifc.is_ex_valid), 32'd0);
    tick();
    check("t3_after_valid", 32'(ifc.is_ex_valid), 32'd1);
    check("t3_after_rd", 32'(ifc.is_ex_regdest), 32'd6);
`endif
    tick();
    check("t3_empty", 32'(is_count), 32'd0);

    // 4: r0 never busy; numop gates the B lookup; numop=2 honours a busy B
    drive_op(5'd0, 1'b1, 2'd0, 5'd0, 5'd0);
    tick();
    drive_op(5'd1, 1'b0, 2'd2, 5'd0, 5'd0);
    tick();
    idle();
    tick();
    check("t4_r0_valid", 32'(ifc.is_ex_valid), 32'd1);
    check("t4_r0_rd", 32'(ifc.is_ex_regdest), 32'd1);
    drive_op(5'd9, 1'b1, 2'd0, 5'd0, 5'd0);
    tick();
    drive_op(5'd2, 1'b0, 2'd1, 5'd3, 5'd9);
    tick();
    idle();
    tick();
    check("t4_nop1_valid", 32'(ifc.is_ex_valid), 32'd1);
    check("t4_nop1_rd", 32'(ifc.is_ex_regdest), 32'd2);
    drive_op(5'd3, 1'b0, 2'd2, 5'd0, 5'd9);
    tick();
    idle();
    tick();
    check("t4_nop2_held", 32'(ifc.is_ex_valid), 32'd0);
    wb_is_writereg = 1'b1;
    wb_is_regdest  = 5'd9;
    tick();
    wb_is_writereg = 1'b0;
    wait_valid("t4_nop2_rel", 5'd3);
    tick();

    // 5: set and clear of r7 in the same cycle leaves r7 busy
    drive_op(5'd7, 1'b1, 2'd0, 5'd0, 5'd0);
    tick();
    idle();
    wb_is_writereg = 1'b1;
    wb_is_regdest  = 5'd7;
    tick();
    wb_is_writereg = 1'b0;
    check("t5_w_rd", 32'(ifc.is_ex_regdest), 32'd7);
    drive_op(5'd8, 1'b0, 2'd1, 5'd7, 5'd0);
    tick();
    idle();
    tick();
    check("t5_held", 32'(ifc.is_ex_valid), 32'd0);
    tick();
    check("t5_held2", 32'(ifc.is_ex_valid), 32'd0);
    wb_is_writereg = 1'b1;
    wb_is_regdest  = 5'd7;
    tick();
    wb_is_writereg = 1'b0;
    wait_valid("t5_rel", 5'd8);
    tick();
    check("t5_empty", 32'(is_count), 32'd0);

    // 6: ten push+pop pairs wrap both pointers
    drive_op(5'd11, 1'b0, 2'd0, 5'd0, 5'd0);
    tick();
    for (int i = 1; i <= 10; i++) begin
      drive_op(5'(11 + i), 1'b0, 2'd0, 5'd0, 5'd0);
      tick();
      check("t6_valid", 32'(ifc.is_ex_valid), 32'd1);
      check("t6_rd", 32'(ifc.is_ex_regdest), 32'(10 + i));
      check("t6_count", 32'(is_count), 32'd1);
    end
    idle();
    tick();
    check("t6_last_rd", 32'(ifc.is_ex_regdest), 32'd21);
    check("t6_last_imm", ifc.is_ex_imedext, 32'hA000_0015);
    check("t6_last_alu", 32'(ifc.is_ex_aluop), 32'd5);
    check("t6_empty", 32'(is_count), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
